// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue: default width, the
// redirect-drain state and the layout of a buffered {pc, data} entry.
package fetch_pkg;

  localparam int DEFAULT_XLEN = 32;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [DEFAULT_XLEN-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage, occupancy count and a
// single-cycle clear that wins over push and pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch queue: issues imem reads from the PC stream under a shared credit,
// pairs in-order responses with their PC, and drains stale reads on redirect.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = DEFAULT_XLEN
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     stale_cnt_q, stale_cnt_d;

  logic [CW-1:0]     tag_count, out_count;
  logic              tag_full, tag_empty, out_full, out_empty;
  logic [XLEN-1:0]   tag_head;
  logic [2*XLEN-1:0] out_head;
  logic [CW:0]       credit_used;
  logic              can_issue, issue, rsp_ok, deliver, out_pop;

  // One credit covers a read from issue until decode takes it.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, out_count};
  assign can_issue   = (state_q == RUN) && !flush && (credit_used < (CW+1)'(DEPTH));
  assign imem_req    = pc_valid && can_issue;
  assign imem_addr   = pc_in;
  assign pc_ready    = imem_req && imem_gnt;
  assign issue       = pc_ready;

  assign rsp_ok      = imem_rvalid && (outstanding_q != '0);
  assign deliver     = rsp_ok && (state_q == RUN) && !flush;
  assign inst_valid  = !out_empty;
  assign out_pop     = inst_valid && inst_ready;
  assign {inst_pc, inst_data} = out_head;

  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk_i   (clock),
    .rst_ni  (rst_n),
    .clear_i (flush),
    .push_i  (issue),
    .data_i  (pc_in),
    .pop_i   (deliver),
    .data_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_count)
  );

  sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_out_fifo (
    .clk_i   (clock),
    .rst_ni  (rst_n),
    .clear_i (flush),
    .push_i  (deliver),
    .data_i  ({tag_head, imem_rdata}),
    .pop_i   (out_pop),
    .data_o  (out_head),
    .full_o  (out_full),
    .empty_o (out_empty),
    .count_o (out_count)
  );

  // A response landing in the flush cycle is already accounted for, so it
  // does not count towards the reads still to be discarded.
  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    stale_cnt_d   = stale_cnt_q;
    if (flush) begin
      outstanding_d = outstanding_q - CW'(rsp_ok);
      stale_cnt_d   = outstanding_d;
      state_d       = (outstanding_d != '0) ? DRAIN : RUN;
    end else if (state_q == DRAIN) begin
      if (rsp_ok && stale_cnt_q != '0) begin
        outstanding_d = outstanding_q - CW'(1);
        stale_cnt_d   = stale_cnt_q - CW'(1);
        if (stale_cnt_q == CW'(1)) state_d = RUN;
      end
    end else begin
      unique case ({issue, deliver})
        2'b10:   outstanding_d = outstanding_q + CW'(1);
        2'b01:   outstanding_d = outstanding_q - CW'(1);
        default: outstanding_d = outstanding_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      outstanding_q <= '0;
      stale_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      stale_cnt_q   <= stale_cnt_d;
    end
  end

  a_rvalid_protocol: assert property (@(posedge clock) disable iff (!rst_n)
    imem_rvalid |-> (outstanding_q != '0));
  a_out_no_overflow: assert property (@(posedge clock) disable iff (!rst_n)
    !(deliver && out_full));
  a_tag_no_overflow: assert property (@(posedge clock) disable iff (!rst_n)
    !(issue && tag_full));
  a_tag_no_underflow: assert property (@(posedge clock) disable iff (!rst_n)
    !(deliver && tag_empty));
  a_tag_tracks_credit: assert property (@(posedge clock) disable iff (!rst_n)
    (state_q == RUN) |-> (tag_count == outstanding_q));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scenario bench for instr_fetch_queue: a latency-1 memory model and a
// scoreboard of granted PCs checked against every decode handshake.
module tb_instr_fetch_queue;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int          vectors = 0;
  int          miscompares = 0;
  int          grantCnt = 0;
  int          popCnt = 0;
  logic        lastGrant = 1'b0;
  bit          memHold = 1'b0;
  logic [31:0] expPc[$];
  logic [31:0] memQ[$];

  instr_fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] dataOf(input logic [31:0] pc);
    return (pc * 32'h0000_9E37) ^ 32'hC0DE_0000;
  endfunction

  // One clock: score the decode handshake and grant, then let the memory
  // model answer the oldest granted read one cycle later.
  task automatic tick();
    logic [31:0] pc;
    #1;
    lastGrant = imem_req && imem_gnt;
    if (inst_valid && inst_ready) begin
      popCnt++;
      vectors++;
      if (expPc.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_pop: got pc=%h data=%h, required no instruction", inst_pc, inst_data);
      end else begin
        pc = expPc.pop_front();
        if (inst_pc !== pc || inst_data !== dataOf(pc)) begin
          miscompares++;
          $display("[TB] FAIL pop_order: got pc=%h data=%h, required pc=%h data=%h",
                   inst_pc, inst_data, pc, dataOf(pc));
        end
      end
    end
    if (lastGrant) begin
      grantCnt++;
      expPc.push_back(imem_addr);
      memQ.push_back(imem_addr);
    end
    if (flush) expPc.delete();
    @(posedge clock);
    @(negedge clock);
    imem_rvalid = 1'b0;
    if (!memHold && memQ.size() > 0) begin
      pc = memQ.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = dataOf(pc);
    end
  endtask

  task automatic drainAll(input int required);
    int startPops;
    startPops  = popCnt;
    pc_valid   = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 40 && (expPc.size() > 0 || inst_valid); i++) tick();
    vectors++;
    if (popCnt - startPops != required || expPc.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain_count: got %0d pops (%0d left), required %0d pops",
               popCnt - startPops, expPc.size(), required);
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_valid = 1'b0; pc_in = '0; flush = 1'b0; imem_gnt = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    #12;
    vectors += 5;
    if (inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_inst_valid: got %b, required 0", inst_valid); end
    if (imem_req !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_imem_req: got %b, required 0", imem_req); end
    if (pc_ready !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_pc_ready: got %b, required 0", pc_ready); end
    if (inst_data !== '0)    begin miscompares++; $display("[TB] FAIL reset_inst_data: got %h, required 0", inst_data); end
    if (inst_pc !== '0)      begin miscompares++; $display("[TB] FAIL reset_inst_pc: got %h, required 0", inst_pc); end
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    pc_valid = 1'b1; pc_in = 32'h0; imem_gnt = 1'b1; inst_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      vectors++;
      if (pc_ready !== (i < 4)) begin
        miscompares++;
        $display("[TB] FAIL stream_pc_ready[%0d]: got %b, required %b", i, pc_ready, (i < 4));
      end
      tick();
      if (lastGrant) pc_in = pc_in + 1;
    end
    vectors += 2;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL stream_head: got valid=%b pc=%h, required valid=1 pc=0", inst_valid, inst_pc);
    end
    if (inst_data !== dataOf(32'h0)) begin
      miscompares++;
      $display("[TB] FAIL stream_head_data: got %h, required %h", inst_data, dataOf(32'h0));
    end
    drainAll(4);
  endtask

  task automatic test_backpressure();
    pc_valid = 1'b1; pc_in = 32'h10; inst_ready = 1'b0; grantCnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (lastGrant) pc_in = pc_in + 1;
    end
    #1;
    vectors += 2;
    if (grantCnt != 4) begin miscompares++; $display("[TB] FAIL bp_grants: got %0d, required 4", grantCnt); end
    if (pc_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_pc_ready: got %b, required 0", pc_ready); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (lastGrant) pc_in = pc_in + 1;
    end
    vectors++;
    if (grantCnt != 5) begin miscompares++; $display("[TB] FAIL bp_one_pop_one_grant: got %0d grants, required 5", grantCnt); end
    drainAll(4);
  endtask

  task automatic test_flush_drain();
    inst_ready = 1'b0; pc_valid = 1'b1; pc_in = 32'h5; memHold = 1'b0;
    tick();
    pc_in = 32'h6; memHold = 1'b1;
    tick();
    pc_in = 32'h7;
    tick();
    pc_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; pc_valid = 1'b1; pc_in = 32'h20;
    #1;
    vectors += 2;
    if (inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_inst_valid: got %b, required 0", inst_valid); end
    if (imem_req !== 1'b0)   begin miscompares++; $display("[TB] FAIL flush_drain_req0: got %b, required 0", imem_req); end
    memHold = 1'b0;
    tick();
    for (int i = 1; i < 3; i++) begin
      #1;
      vectors++;
      if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_drain_req%0d: got %b, required 0", i, imem_req); end
      tick();
    end
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      miscompares++;
      $display("[TB] FAIL flush_resume: got req=%b addr=%h, required req=1 addr=00000020", imem_req, imem_addr);
    end
    tick();
    drainAll(1);
  endtask

  task automatic test_flush_rvalid();
    inst_ready = 1'b0; pc_valid = 1'b1; pc_in = 32'h30; memHold = 1'b0;
    tick();
    pc_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; pc_valid = 1'b1; pc_in = 32'h31;
    #1;
    vectors += 2;
    if (inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flushrv_inst_valid: got %b, required 0", inst_valid); end
    if (imem_req !== 1'b1)   begin miscompares++; $display("[TB] FAIL flushrv_issue: got %b, required 1", imem_req); end
    tick();
    drainAll(1);
  endtask

  task automatic test_gnt_stall();
    inst_ready = 1'b0; pc_valid = 1'b1; pc_in = 32'h40; imem_gnt = 1'b0; grantCnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40 || pc_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall[%0d]: got req=%b addr=%h ready=%b, required req=1 addr=00000040 ready=0",
                 i, imem_req, imem_addr, pc_ready);
      end
      tick();
    end
    imem_gnt = 1'b1;
    tick();
    vectors++;
    if (grantCnt != 1) begin miscompares++; $display("[TB] FAIL stall_grants: got %0d, required 1", grantCnt); end
    drainAll(1);
  endtask

  task automatic test_reset_drain();
    inst_ready = 1'b0; pc_valid = 1'b1; memHold = 1'b1;
    pc_in = 32'h50; tick();
    pc_in = 32'h51; tick();
    pc_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0; pc_valid = 1'b1;
    #1;
    vectors++;
    if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_drain_state: got req=%b, required 0", imem_req); end
    pc_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    vectors += 2;
    if (inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_inst_valid: got %b, required 0", inst_valid); end
    if (imem_req !== 1'b0)   begin miscompares++; $display("[TB] FAIL rst_mid_imem_req: got %b, required 0", imem_req); end
    memQ.delete();
    expPc.delete();
    imem_rvalid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1; memHold = 1'b0; pc_valid = 1'b1; pc_in = 32'h60; grantCnt = 0;
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h60) begin
      miscompares++;
      $display("[TB] FAIL rst_fresh_req: got req=%b addr=%h, required req=1 addr=00000060", imem_req, imem_addr);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (lastGrant) pc_in = pc_in + 1;
    end
    vectors++;
    if (grantCnt != 4) begin miscompares++; $display("[TB] FAIL rst_fresh_grants: got %0d, required 4", grantCnt); end
    drainAll(4);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_drain();
    test_flush_rvalid();
    test_gnt_stall();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
